pipe_stage_queue: RTL

//  Parametrised inter-stage pipeline buffer; generalises the fixed fetch/decode/execute/memory register

---
 rtl/pipe_stage_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_stage_queue.sv
// Inter-stage pipeline FIFO with valid/ready backpressure, flush and occupancy reporting.
// Optional zero-latency cut-through when empty is enabled by defining PIPE_STAGE_BYPASS_EN.
module pipe_stage_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic full_s;
    logic empty_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;

    // Occupancy flags and handshake qualification.
    always_comb begin
        full_s  = (count_r == CNT_W'(DEPTH));
        empty_s = (count_r == {CNT_W{1'b0}});
`ifdef PIPE_STAGE_BYPASS_EN
        bypass_s = empty_s & in_valid & out_ready;
`else
        bypass_s = 1'b0;
`endif
        // A cut-through beat leaves straight away, so it is neither stored nor popped.
        push_s = in_valid & (~full_s | out_ready) & ~bypass_s;
        pop_s  = ~empty_s & out_ready;
    end

    // Output port drive; the stored head is masked to zero while the queue is empty.
    always_comb begin
        in_ready = ~full_s | out_ready;
        count    = count_r;
        full     = full_s;
        empty    = empty_s;
        if (bypass_s) begin
            out_valid = ~flush;
            out_data  = in_data;
        end else if (empty_s) begin
            out_valid = 1'b0;
            out_data  = {WIDTH{1'b0}};
        end else begin
            out_valid = 1'b1;
            out_data  = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy state; flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; deliberately not reset since empty masks it at the output.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

endmodule
